ft245_sff_device: RTL and testbench
===================================

# ft245_sff_device

Cycle-accurate device-side model of the FT245 synchronous FIFO interface: it plays the USB chip's part against the FPGA host-interface block. A stimulus port loads bytes that the FPGA then reads through RXFn/OEn/RDn. Bytes the FPGA writes through TXEn/WRn are buffered and handed back on a drain port. Used in cocotb loopback benches and as a synthesizable stand-in for the chip in on-board self-test builds.

## Interface
- RX_DEPTH, 16: host-to-FPGA FIFO depth in bytes; power of 2, at least 2.
- TX_DEPTH, 16: FPGA-to-host FIFO depth in bytes; power of 2, at least 2.
- Clk  in  1  single clock; all state updates on the rising edge; stands in for the FT245 60 MHz CLKOUT.
- Rstn  in  1  reset; synchronous and active-low.
- RXFn  out  1  low when the RX FIFO holds at least one byte.
- TXEn  out  1  low when the TX FIFO has room.
- RDn  in  1  FPGA read strobe, active low.
- WRn  in  1  FPGA write strobe, active low.
- OEn  in  1  FPGA output-enable request, active low.
- DOUT  out  8  RX FIFO head byte; meaningful only while DOE=1.
- DOE  out  1  equals ~OEn, combinational; the bench uses it to drive the shared bus.
- DIN  in  8  bus data from the FPGA, sampled on writes.
- HostTxData  in  8  byte to queue for the FPGA.
- HostTxValid  in  1  push request.
- HostTxReady  out  1  RX FIFO not full.
- HostRxData  out  8  TX FIFO head byte.
- HostRxValid  out  1  TX FIFO not empty.
- HostRxReady  in  1  pop request.
- RxLevel  out  clog2(RX_DEPTH)+1  RX FIFO occupancy.
- TxLevel  out  clog2(TX_DEPTH)+1  TX FIFO occupancy.
- RdErr  out  1  sticky protocol-error flag for reads.
- WrErr  out  1  sticky protocol-error flag for writes.

## Operation
- RX path (host to FPGA):
  - A push happens on an edge where HostTxValid=1 and HostTxReady=1.
  - A pop happens on an edge where RDn=0, OEn=0 and RXFn=0.
  - DOUT is the RX FIFO head, driven combinationally from the storage read pointer. After a pop, the next byte is presented in the following cycle.
- TX path (FPGA to host):
  - A write happens on an edge where WRn=0 and TXEn=0; DIN is stored.
  - A drain happens on an edge where HostRxValid=1 and HostRxReady=1.
- Flag registers:
  - RXFn is registered as (next RxLevel == 0).
  - TXEn is registered as (next TxLevel == TX_DEPTH).
  - Flags therefore reflect the same-edge push and pop, with no stale cycle.
- Ready/valid outputs are combinational from the current level:
  - HostTxReady = (RxLevel != RX_DEPTH).
  - HostRxValid = (TxLevel != 0).
- Simultaneous push and pop on a FIFO: level is unchanged and both transfers take effect.
  - A push while full is refused even if a pop occurs on the same edge.
  - A pop while empty cannot occur, because the flag gates it.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH; levels saturate by construction.
- RdErr is set on any edge where RDn=0 and (RXFn=1 or OEn=1). No pop occurs on that edge.
- WrErr is set on any edge where WRn=0 and either condition holds:
  - TXEn=1: the write is dropped.
  - OEn=0: bus contention; the write is dropped.
- RdErr and WrErr are sticky until reset.
- RDn=0 and WRn=0 on the same edge: WRn=0 with OEn=0 already flags WrErr. If OEn=1, RdErr is set and the write proceeds normally.

## Timing
- Reset, on an edge where Rstn=0:
  - Both FIFOs are emptied and pointers zeroed.
  - RXFn=1, TXEn=1, RdErr=0, WrErr=0.
  - RxLevel=0, TxLevel=0, HostTxReady=1, HostRxValid=0.
  - DOUT and HostRxData are don't-care.
- TXEn falls on the first edge with Rstn=1.
- Reset mid-burst discards all queued bytes. A strobe held low through reset release is evaluated normally from the first edge with Rstn=1.
- Push latency: a byte pushed at edge N gives RXFn=0 after edge N, and DOUT shows it whenever OEn=0 from that cycle.
- Read burst: with OEn low from cycle k and RDn low from cycle k+1, one byte pops per edge while RXFn=0.
- The last pop in a burst raises RXFn at that same edge. An FPGA still asserting RDn in the next cycle triggers RdErr.
- Write latency: a byte written at edge N gives HostRxValid=1 after edge N.
- TXEn rises at the edge that fills the FIFO. It falls at the edge where a drain leaves room, provided no write fills it again.

## Test plan
- Reset and flags:
  - Stimulus: hold Rstn=0 for 3 cycles, then release.
  - Required response: RXFn=1 throughout, TXEn=1 during reset and 0 one edge after release, both levels 0, errors 0.
- RX burst:
  - Stimulus: push 0x11, 0x22, 0x33; OEn=0 at cycle k; RDn=0 for cycles k+1 to k+3.
  - Required response: DOUT shows 0x11, then 0x22, then 0x33; RXFn rises at the third pop edge; RdErr=0.
- RX fill:
  - Stimulus: push 16 bytes (0x00 to 0x0F) at the default depth, then a 17th push concurrent with a pop.
  - Required response: HostTxReady=0 and RxLevel=16; the 17th byte is refused; the pop succeeds; RxLevel=15.
- TX full:
  - Stimulus: with HostRxReady=0, FPGA writes 0xA0 to 0xAF back-to-back, then one more write.
  - Required response: TXEn rises at the 16th edge; the 17th write is dropped and sets WrErr; draining returns 0xA0 to 0xAF in order.
- Wrap-around:
  - Stimulus: 40 bytes streamed each way with random Valid/Ready and strobe gaps.
  - Required response: byte order is preserved on both paths across pointer wrap; no error flags.
- Protocol errors:
  - Stimulus: RDn=0 with OEn=1; separately, WRn=0 with OEn=0.
  - Required response: RdErr=1 with no pop; WrErr=1 with no write; both flags remain set until Rstn=0.

Source files
------------

// File: rtl/ft245_sff_device.sv
// ft245_sff_device: device-side model of the FT245 synchronous FIFO interface.
// The RX FIFO is loaded from the host port and read by the FPGA through
// RXFn/OEn/RDn; the TX FIFO is written by the FPGA through TXEn/WRn and drained
// on the host port. RXFn/TXEn are registered from next-cycle occupancy so they
// already reflect the push and pop taken on the same edge.
module ft245_sff_device #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    output logic                        o_rxfn,
    output logic                        o_txen,
    input  logic                        i_rdn,
    input  logic                        i_wrn,
    input  logic                        i_oen,
    output logic [7:0]                  o_dout,
    output logic                        o_doe,
    input  logic [7:0]                  i_din,
    input  logic [7:0]                  i_host_tx_data,
    input  logic                        i_host_tx_valid,
    output logic                        o_host_tx_ready,
    output logic [7:0]                  o_host_rx_data,
    output logic                        o_host_rx_valid,
    input  logic                        i_host_rx_ready,
    output logic [$clog2(RX_DEPTH):0]   o_rx_level,
    output logic [$clog2(TX_DEPTH):0]   o_tx_level,
    output logic                        o_rd_err,
    output logic                        o_wr_err
);

    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RLW = RAW + 1;
    localparam int TLW = TAW + 1;
    localparam logic [RLW-1:0] RX_FULL = RLW'(RX_DEPTH);
    localparam logic [TLW-1:0] TX_FULL = TLW'(TX_DEPTH);

    // RX path state
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RAW-1:0] r_rx_wp;
    logic [RAW-1:0] r_rx_rp;
    logic [RLW-1:0] r_rx_level;
    logic [RLW-1:0] w_rx_level_nxt;
    logic           r_rxfn;

    // TX path state
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [TAW-1:0] r_tx_wp;
    logic [TAW-1:0] r_tx_rp;
    logic [TLW-1:0] r_tx_level;
    logic [TLW-1:0] w_tx_level_nxt;
    logic           r_txen;

    logic           r_rd_err;
    logic           r_wr_err;

    logic           w_rx_push;
    logic           w_rx_pop;
    logic           w_tx_write;
    logic           w_tx_drain;
    logic           w_rd_err;
    logic           w_wr_err;

    // Transfer qualifiers; pops and writes are gated by the registered flags,
    // and a write with OEn low is bus contention and therefore dropped.
    assign w_rx_push  = i_host_tx_valid & o_host_tx_ready;
    assign w_rx_pop   = ~i_rdn & ~i_oen & ~r_rxfn;
    assign w_rd_err   = ~i_rdn & (r_rxfn | i_oen);
    assign w_tx_write = ~i_wrn & ~r_txen & i_oen;
    assign w_wr_err   = ~i_wrn & (r_txen | ~i_oen);
    assign w_tx_drain = i_host_rx_ready & o_host_rx_valid;

    assign o_rxfn          = r_rxfn;
    assign o_txen          = r_txen;
    assign o_dout          = r_rx_mem[r_rx_rp];
    assign o_doe           = ~i_oen;
    assign o_host_tx_ready = (r_rx_level != RX_FULL);
    assign o_host_rx_data  = r_tx_mem[r_tx_rp];
    assign o_host_rx_valid = (r_tx_level != {TLW{1'b0}});
    assign o_rx_level      = r_rx_level;
    assign o_tx_level      = r_tx_level;
    assign o_rd_err        = r_rd_err;
    assign o_wr_err        = r_wr_err;

    // Next RX occupancy: simultaneous push and pop leave the level unchanged.
    always_comb begin
        w_rx_level_nxt = r_rx_level;
        case ({w_rx_push, w_rx_pop})
            2'b10:   w_rx_level_nxt = r_rx_level + RLW'(1);
            2'b01:   w_rx_level_nxt = r_rx_level - RLW'(1);
            default: w_rx_level_nxt = r_rx_level;
        endcase
    end

    // Next TX occupancy: simultaneous write and drain leave the level unchanged.
    always_comb begin
        w_tx_level_nxt = r_tx_level;
        case ({w_tx_write, w_tx_drain})
            2'b10:   w_tx_level_nxt = r_tx_level + TLW'(1);
            2'b01:   w_tx_level_nxt = r_tx_level - TLW'(1);
            default: w_tx_level_nxt = r_tx_level;
        endcase
    end

    // RX storage write; contents are don't-care after reset, so no reset here.
    always_ff @(posedge i_clk) begin
        if (i_rstn && w_rx_push) begin
            r_rx_mem[r_rx_wp] <= i_host_tx_data;
        end
    end

    // TX storage write; contents are don't-care after reset, so no reset here.
    always_ff @(posedge i_clk) begin
        if (i_rstn && w_tx_write) begin
            r_tx_mem[r_tx_wp] <= i_din;
        end
    end

    // RX pointers, level and RXFn flag.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rx_wp    <= {RAW{1'b0}};
            r_rx_rp    <= {RAW{1'b0}};
            r_rx_level <= {RLW{1'b0}};
            r_rxfn     <= 1'b1;
        end else begin
            if (w_rx_push) begin
                r_rx_wp <= r_rx_wp + RAW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + RAW'(1);
            end
            r_rx_level <= w_rx_level_nxt;
            r_rxfn     <= (w_rx_level_nxt == {RLW{1'b0}});
        end
    end

    // TX pointers, level and TXEn flag; TXEn is held high through reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_tx_wp    <= {TAW{1'b0}};
            r_tx_rp    <= {TAW{1'b0}};
            r_tx_level <= {TLW{1'b0}};
            r_txen     <= 1'b1;
        end else begin
            if (w_tx_write) begin
                r_tx_wp <= r_tx_wp + TAW'(1);
            end
            if (w_tx_drain) begin
                r_tx_rp <= r_tx_rp + TAW'(1);
            end
            r_tx_level <= w_tx_level_nxt;
            r_txen     <= (w_tx_level_nxt == TX_FULL);
        end
    end

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rd_err <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_rd_err <= r_rd_err | w_rd_err;
            r_wr_err <= r_wr_err | w_wr_err;
        end
    end

endmodule

// File: tb/tb_ft245_sff_device.sv
// Testbench for ft245_sff_device: directed vectors plus a queue-based model of
// both FIFOs that is compared against the DUT on every falling edge.
module tb_ft245_sff_device;

    typedef logic [7:0] byte_t;

    logic       clk = 1'b0;
    logic       rstn, rdn, wrn, oen, htv, hrr;
    logic [7:0] din, htd;
    logic       o_rxfn, o_txen, o_doe, o_host_tx_ready, o_host_rx_valid;
    logic       o_rd_err, o_wr_err;
    logic [7:0] o_dout, o_host_rx_data;
    logic [4:0] o_rx_level, o_tx_level;

    ft245_sff_device #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .i_clk(clk), .i_rstn(rstn), .o_rxfn(o_rxfn), .o_txen(o_txen),
        .i_rdn(rdn), .i_wrn(wrn), .i_oen(oen), .o_dout(o_dout), .o_doe(o_doe),
        .i_din(din), .i_host_tx_data(htd), .i_host_tx_valid(htv),
        .o_host_tx_ready(o_host_tx_ready), .o_host_rx_data(o_host_rx_data),
        .o_host_rx_valid(o_host_rx_valid), .i_host_rx_ready(hrr),
        .o_rx_level(o_rx_level), .o_tx_level(o_tx_level),
        .o_rd_err(o_rd_err), .o_wr_err(o_wr_err)
    );

    always #5 clk = ~clk;

    // Model state: plain byte queues plus sticky error bits.
    byte_t rxq[$];
    byte_t txq[$];
    byte_t rx_got[$];
    byte_t tx_got[$];
    bit    m_rd_err = 1'b0;
    bit    m_wr_err = 1'b0;
    bit    m_rst_last = 1'b1;
    bit    m_valid = 1'b0;
    int    rx_pushes = 0;
    int    tx_writes = 0;

    int    checks = 0;
    int    errors = 0;

    byte_t burst[3] = '{8'h11, 8'h22, 8'h33};
    byte_t rx_pat[40];
    byte_t tx_pat[40];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one rising edge to the model using the inputs held across it.
    task automatic model_edge();
        bit rxf, txe, pop, push, wr, drain;
        byte_t b;
        if (!rstn) begin
            rxq.delete();
            txq.delete();
            m_rd_err   = 1'b0;
            m_wr_err   = 1'b0;
            m_rst_last = 1'b1;
            m_valid    = 1'b1;
        end else begin
            rxf   = (rxq.size() == 0);
            txe   = m_rst_last || (txq.size() == 16);
            pop   = !rdn && !oen && !rxf;
            push  = htv && (rxq.size() < 16);
            wr    = !wrn && !txe && oen;
            drain = hrr && (txq.size() > 0);
            if (!rdn && (rxf || oen)) m_rd_err = 1'b1;
            if (!wrn && (txe || !oen)) m_wr_err = 1'b1;
            if (pop) begin
                b = rxq.pop_front();
                rx_got.push_back(b);
            end
            if (push) begin
                rxq.push_back(htd);
                rx_pushes++;
            end
            if (drain) begin
                b = txq.pop_front();
                tx_got.push_back(b);
            end
            if (wr) begin
                txq.push_back(din);
                tx_writes++;
            end
            m_rst_last = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("rxfn", o_rxfn, rxq.size() == 0);
            chk("txen", o_txen, m_rst_last || (txq.size() == 16));
            chk("rx_level", o_rx_level, rxq.size());
            chk("tx_level", o_tx_level, txq.size());
            chk("host_tx_ready", o_host_tx_ready, rxq.size() != 16);
            chk("host_rx_valid", o_host_rx_valid, txq.size() != 0);
            chk("rd_err", o_rd_err, m_rd_err);
            chk("wr_err", o_wr_err, m_wr_err);
            chk("doe", o_doe, !oen);
            if (!oen && rxq.size() > 0) chk("dout", o_dout, rxq[0]);
            if (txq.size() > 0) chk("host_rx_data", o_host_rx_data, txq[0]);
        end
    end

    initial begin
        rstn = 1'b0; rdn = 1'b1; wrn = 1'b1; oen = 1'b1;
        htv = 1'b0; hrr = 1'b0; din = 8'h00; htd = 8'h00;

        // Reset and flags
        repeat (3) begin
            cyc();
            chk("rst_txen", o_txen, 1);
            chk("rst_rxfn", o_rxfn, 1);
            chk("rst_errs", {o_rd_err, o_wr_err}, 0);
        end
        rstn = 1'b1;
        cyc();
        chk("release_txen", o_txen, 0);
        chk("release_levels", {o_rx_level, o_tx_level}, 0);
        chk("release_ready", o_host_tx_ready, 1);

        // RX burst
        for (int i = 0; i < 3; i++) begin
            htv = 1'b1; htd = burst[i];
            cyc();
        end
        htv = 1'b0;
        rx_got.delete();
        oen = 1'b0;
        cyc();
        chk("burst_dout_k", o_dout, 8'h11);
        rdn = 1'b0;
        cyc();
        chk("burst_dout_1", o_dout, 8'h22);
        cyc();
        chk("burst_dout_2", o_dout, 8'h33);
        cyc();
        chk("burst_rxfn_last", o_rxfn, 1);
        rdn = 1'b1; oen = 1'b1;
        chk("burst_count", rx_got.size(), 3);
        for (int i = 0; i < 3 && i < rx_got.size(); i++) chk("burst_byte", rx_got[i], burst[i]);
        cyc();
        chk("burst_rderr", o_rd_err, 0);

        // RX fill
        for (int i = 0; i < 16; i++) begin
            htv = 1'b1; htd = 8'(i);
            cyc();
        end
        htv = 1'b0;
        chk("fill_level", o_rx_level, 16);
        chk("fill_ready", o_host_tx_ready, 0);
        rx_got.delete();
        htv = 1'b1; htd = 8'h99; oen = 1'b0; rdn = 1'b0;
        cyc();
        htv = 1'b0; rdn = 1'b1;
        chk("fill_level_after", o_rx_level, 15);
        chk("fill_pop_byte", rx_got.size() > 0 ? rx_got[0] : 8'hFF, 8'h00);
        rx_got.delete();
        rdn = 1'b0;
        repeat (15) cyc();
        rdn = 1'b1; oen = 1'b1;
        chk("fill_drain_count", rx_got.size(), 15);
        for (int i = 0; i < 15 && i < rx_got.size(); i++) chk("fill_drain_byte", rx_got[i], i + 1);
        cyc();

        // TX full
        hrr = 1'b0; oen = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wrn = 1'b0; din = 8'hA0 + 8'(i);
            cyc();
        end
        chk("txfull_txen", o_txen, 1);
        chk("txfull_level", o_tx_level, 16);
        din = 8'hBB;
        cyc();
        wrn = 1'b1;
        chk("txfull_wrerr", o_wr_err, 1);
        chk("txfull_level_17", o_tx_level, 16);
        tx_got.delete();
        hrr = 1'b1;
        repeat (16) cyc();
        hrr = 1'b0;
        chk("txfull_drain_count", tx_got.size(), 16);
        for (int i = 0; i < 16 && i < tx_got.size(); i++) chk("txfull_drain_byte", tx_got[i], 8'hA0 + i);
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
        chk("reset_clears_wrerr", o_wr_err, 0);

        // Wrap-around streaming in both directions
        for (int i = 0; i < 40; i++) begin
            rx_pat[i] = 8'(i * 7 + 3);
            tx_pat[i] = 8'hC0 ^ 8'(i * 5);
        end
        rx_got.delete(); tx_got.delete();
        rx_pushes = 0; tx_writes = 0;
        for (int n = 0; n < 3000 && (rx_got.size() < 40 || tx_got.size() < 40); n++) begin
            htv = (rx_pushes < 40) && ($urandom_range(0, 1) == 1);
            htd = rx_pat[rx_pushes < 40 ? rx_pushes : 0];
            hrr = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) begin
                oen = 1'b0; wrn = 1'b1;
                rdn = !((rxq.size() > 0) && ($urandom_range(0, 2) != 0));
            end else begin
                oen = 1'b1; rdn = 1'b1;
                wrn = !((tx_writes < 40) && !(m_rst_last || txq.size() == 16) &&
                        ($urandom_range(0, 2) != 0));
                din = tx_pat[tx_writes < 40 ? tx_writes : 0];
            end
            cyc();
        end
        htv = 1'b0; hrr = 1'b0; rdn = 1'b1; wrn = 1'b1; oen = 1'b1;
        chk("wrap_rx_count", rx_got.size(), 40);
        chk("wrap_tx_count", tx_got.size(), 40);
        for (int i = 0; i < 40 && i < rx_got.size(); i++) chk("wrap_rx_byte", rx_got[i], rx_pat[i]);
        for (int i = 0; i < 40 && i < tx_got.size(); i++) chk("wrap_tx_byte", tx_got[i], tx_pat[i]);
        chk("wrap_errs", {o_rd_err, o_wr_err}, 0);
        cyc();

        // Protocol errors
        htv = 1'b1; htd = 8'h5A;
        cyc();
        htv = 1'b0; oen = 1'b1; rdn = 1'b0;
        cyc();
        rdn = 1'b1;
        chk("proto_rderr", o_rd_err, 1);
        chk("proto_no_pop", o_rx_level, 1);
        oen = 1'b0; wrn = 1'b0; din = 8'h77;
        cyc();
        wrn = 1'b1; oen = 1'b1;
        chk("proto_wrerr", o_wr_err, 1);
        chk("proto_no_write", o_tx_level, 0);
        repeat (3) cyc();
        chk("proto_sticky", {o_rd_err, o_wr_err}, 2'b11);
        rstn = 1'b0;
        cyc();
        chk("proto_reset_clear", {o_rd_err, o_wr_err}, 2'b00);
        rstn = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
